// File: rtl/a2d_pkg.sv
// Shared types and sizes for the A2D scan sequencer.
package a2d_pkg;

  localparam int NUM_CHNL = 8;
  localparam int RES_W    = 12;
  localparam int CHNL_W   = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/a2d_next_chnl.sv
// Combinational priority finder: lowest set mask bit strictly above i_ptr.
// Pass i_ptr = -1 to find the lowest set bit of the whole mask.
module a2d_next_chnl
  import a2d_pkg::*;
(
  input  logic [NUM_CHNL-1:0]  i_mask,
  input  logic signed [CHNL_W:0] i_ptr,
  output logic [CHNL_W-1:0]    o_nxt,
  output logic                 o_found
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    o_nxt   = '0;
    o_found = 1'b0;
    for (int i = NUM_CHNL - 1; i >= 0; i--) begin
      if (i_mask[i] && (i > int'(i_ptr))) begin
        o_nxt   = CHNL_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Owns the A2D_intf: periodic round-robin scan over an enable mask, one-shot
// on-demand conversions slotted in between, and a per-channel result file.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int GAP_CYC    = 16,
  parameter int PERIOD_CYC = 65536,
  parameter int TMO_CYC    = 1024,
  parameter bit INV_RES    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_en,
  input  logic [NUM_CHNL-1:0] chnl_mask,
  input  logic                od_req,
  input  logic [CHNL_W-1:0]   od_chnl,
  output logic                od_ack,
  output logic [RES_W-1:0]    od_res,
  output logic                strt_cnv,
  output logic [CHNL_W-1:0]   chnnl,
  input  logic                cnv_cmplt,
  input  logic [RES_W-1:0]    res,
  input  logic [CHNL_W-1:0]   rd_chnl,
  output logic [RES_W-1:0]    rd_res,
  output logic                rd_vld,
  output logic                scan_done,
  output logic                tmo_err,
  output logic [2:0]          dbg_state
);

  localparam int MAX_CYC = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PER_W   = $clog2(PERIOD_CYC);

  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [PER_W-1:0]    r_per_cnt;
  logic                r_scan_pend;
  logic                r_pass_act;
  logic [CHNL_W-1:0]   r_ptr;
  logic                r_od_flag;
  logic [CHNL_W-1:0]   r_od_chnl;
  logic [RES_W-1:0]    r_od_res;
  logic [RES_W-1:0]    r_res [NUM_CHNL];
  logic [NUM_CHNL-1:0] r_vld;
  logic                r_scan_done;
  logic                r_tmo_err;

  logic [RES_W-1:0]    w_res_in;
  logic [CHNL_W-1:0]   w_chnnl;
  logic [CHNL_W-1:0]   w_first;
  logic                w_first_found;
  logic [CHNL_W-1:0]   w_next;
  logic                w_next_found;
  logic                w_gap_done;
  logic                w_od_grant;
  logic                w_pass_start;
  logic                w_cmplt;
  logic                w_tmo;
  logic                w_advance;

  a2d_next_chnl u_first (
    .i_mask  (chnl_mask),
    .i_ptr   ({(CHNL_W + 1){1'b1}}),
    .o_nxt   (w_first),
    .o_found (w_first_found)
  );

  a2d_next_chnl u_next (
    .i_mask  (chnl_mask),
    .i_ptr   ({1'b0, r_ptr}),
    .o_nxt   (w_next),
    .o_found (w_next_found)
  );

  assign w_res_in     = INV_RES ? ~res : res;
  assign w_chnnl      = r_od_flag ? r_od_chnl : r_ptr;
  assign w_gap_done   = (r_state == GAP) && (r_cnt == GAP_LAST);
  assign w_od_grant   = od_req && ((r_state == IDLE) || w_gap_done);
  assign w_pass_start = (r_state == IDLE) && !od_req && r_scan_pend && scan_en && w_first_found;
  assign w_cmplt      = (r_state == WAIT) && cnv_cmplt;
  assign w_tmo        = (r_state == WAIT) && !cnv_cmplt && (r_cnt == TMO_LAST);
  // A timed-out scan channel still moves the pointer on; only STORE may end with scan_done.
  assign w_advance    = !r_od_flag && ((r_state == STORE) || w_tmo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_od_grant || w_pass_start) w_state_nxt = START;
      START: if (r_cnt == CNT_W'(1)) w_state_nxt = WAIT;
      WAIT: begin
        if (cnv_cmplt)              w_state_nxt = STORE;
        else if (r_cnt == TMO_LAST) w_state_nxt = GAP;
      end
      STORE: w_state_nxt = GAP;
      GAP:   if (w_gap_done) w_state_nxt = (od_req || r_pass_act) ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strt_cnv  = (r_state == START);
    od_ack    = (r_state == STORE) && r_od_flag;
    chnnl     = w_chnnl;
    od_res    = r_od_res;
    scan_done = r_scan_done;
    tmo_err   = r_tmo_err;
    dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_per_cnt   <= '0;
      r_scan_pend <= 1'b0;
    end else begin
      r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
      if (!scan_en) begin
        r_per_cnt   <= '0;
        r_scan_pend <= 1'b0;
      end else begin
        r_per_cnt <= (r_per_cnt == PER_LAST) ? '0 : r_per_cnt + PER_W'(1);
        if (r_per_cnt == PER_LAST) r_scan_pend <= 1'b1;
        else if (w_pass_start)     r_scan_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_pass_act  <= 1'b0;
      r_scan_done <= 1'b0;
      r_od_flag   <= 1'b0;
      r_od_chnl   <= '0;
      r_od_res    <= '0;
      r_vld       <= '0;
      r_tmo_err   <= 1'b0;
      for (int i = 0; i < NUM_CHNL; i++) r_res[i] <= '0;
    end else begin
      r_scan_done <= 1'b0;
      if (w_pass_start) begin
        r_ptr      <= w_first;
        r_pass_act <= 1'b1;
      end else if (w_advance) begin
        if (!scan_en || (chnl_mask == '0)) begin
          r_pass_act <= 1'b0;
        end else if (w_next_found) begin
          r_ptr <= w_next;
        end else begin
          r_pass_act  <= 1'b0;
          r_scan_done <= (r_state == STORE);
        end
      end

      if (w_od_grant) begin
        r_od_flag <= 1'b1;
        r_od_chnl <= od_chnl;
      end else if (r_od_flag && ((r_state == STORE) || w_tmo)) begin
        r_od_flag <= 1'b0;
      end

      // Written on the completion edge so od_res is already valid while od_ack is high.
      if (w_cmplt) begin
        r_res[w_chnnl] <= w_res_in;
        r_vld[w_chnnl] <= 1'b1;
        if (r_od_flag) r_od_res <= w_res_in;
      end

      if (w_tmo) r_tmo_err <= 1'b1;
    end
  end

  assign rd_res = r_res[rd_chnl];
  assign rd_vld = r_vld[rd_chnl];

endmodule

// File: doc/a2d_scan_ctrl.md
Name: a2d_scan_ctrl

Overview:
- Sequencer that owns the single A2D_intf instance (SPI link to the ADC128S).
- Runs a background round-robin scan over a programmable 8-channel enable mask.
- Grants one-shot on-demand conversions ahead of the scan, at the next conversion slot.
- Captures each 12-bit result into a per-channel register file for consumers: steering, battery monitor and similar.

Parameters:
- GAP_CYC, 16: idle clocks between end of one conversion and next strt_cnv (lets A2D_intf return to idle).
- PERIOD_CYC, 2^16: clocks from the start of one scan pass to the start of the next.
- TMO_CYC, 1024: clocks to wait for cnv_cmplt before declaring timeout.
- INV_RES, 1: 1 = store ~res (ADC path is inverted); 0 = store res.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- scan_en, input, 1: enables periodic background scanning.
- chnl_mask, input, 8: bit i=1 includes channel i in the scan.
- od_req, input, 1: on-demand conversion request, level; held until od_ack.
- od_chnl, input, 3: channel for the on-demand request; sampled when the request is granted.
- od_ack, output, 1: one-clock pulse when on-demand result is available.
- od_res, output, 12: on-demand result, held until the next od_ack.
- strt_cnv, output, 1: to A2D_intf.
- chnnl, output, 3: to A2D_intf; stable from strt_cnv through cnv_cmplt.
- cnv_cmplt, input, 1: from A2D_intf, one-clock pulse.
- res, input, 12: from A2D_intf, valid with cnv_cmplt.
- rd_chnl, input, 3: read address for the result file.
- rd_res, output, 12: combinational read of the result register at rd_chnl.
- rd_vld, output, 1: result at rd_chnl has been written since reset.
- scan_done, output, 1: one-clock pulse after the last enabled channel of a pass is stored.
- tmo_err, output, 1: sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset values: all outputs 0; result regs 0; valid bits 0; state IDLE; period counter 0.
- Period counter:
  - free-runs while scan_en=1; cleared while scan_en=0;
  - at PERIOD_CYC-1 it wraps and sets scan_pend;
  - scan_pend is cleared when a pass starts.
- FSM states:
  - IDLE: if od_req, latch od_chnl, set od_flag, go START. Else if scan_pend and chnl_mask!=0, load ptr=lowest set mask bit, go START. od_req has priority.
  - START: strt_cnv=1 for exactly 2 clocks, chnnl driven; then go WAIT. The 2-clock pulse matches A2D_intf's tested usage.
  - WAIT: tmo counter runs.
    - On cnv_cmplt: write the result (INV_RES applied), go STORE.
    - At TMO_CYC: set tmo_err, write nothing, go GAP; the scan continues with the next channel.
  - STORE:
    - If od_flag: od_res updated, od_ack pulses, od_flag cleared.
    - Else: set valid[ptr]; advance ptr to next set bit above ptr. If none, pulse scan_done and end the pass.
    - Go GAP.
  - GAP: count GAP_CYC, then:
    - od_req pending → START (on-demand);
    - else pass in progress → START (scan, next ptr);
    - else → IDLE.
- On-demand conversions insert between scan channels; the scan resumes at the saved ptr afterwards.
- chnl_mask is sampled at each ptr advance. Bits cleared mid-pass are skipped. If the mask becomes 0 mid-pass, the pass ends without scan_done.
- scan_pend set while a pass is in progress is held; the next pass starts immediately after the current one ends. Max one pending pass.
- scan_en dropping mid-pass: the current conversion completes and stores; the pass then ends; no scan_done.
- A cnv_cmplt arriving outside WAIT is ignored.
- Asynchronous reset mid-conversion: FSM to IDLE immediately; the A2D_intf is reset by the same rst_n.
- Write and read of the same channel in one clock: rd_res shows the old value; it updates the next clock.

Decomposition:
- Shared package a2d_pkg:
  - state enum (IDLE, START, WAIT, STORE, GAP);
  - NUM_CHNL=8, RES_W=12, CHNL_W=3.
- One sub-module, a2d_next_chnl: combinational priority finder. Inputs: mask, ptr. Outputs: next set bit above ptr, plus a found flag. Also used for the lowest-bit search with ptr=-1.
- Result file and FSM stay in the top.

Test Plan:
- Full scan: mask=8'hFF, scan_en=1, ADC128S model with known data → 8 conversions on channels 0..7 in order; each rd_res equals the expected value (the inverted ADC word); rd_vld=1 for all; exactly one scan_done.
- Sparse mask: mask=8'b1010_0100 → chnnl sequence 2,5,7; rd_vld only for 2,5,7; at least GAP_CYC clocks between cnv_cmplt and the next strt_cnv.
- On-demand preemption: during a full scan, assert od_req with od_chnl=3 while converting channel 1 → next conversion is channel 3; od_ack pulses with od_res matching channel 3 data; scan then resumes at channel 2.
- Timeout: cnv_cmplt is forced low (model disconnected) → tmo_err=1 after TMO_CYC clocks in WAIT; the next channel is still started; tmo_err stays set until rst_n.
- Mid-pass changes: clear mask bit 6 while channel 4 converts → channel 6 skipped. Drop scan_en during channel 5 → channel 5 stored; no scan_done; FSM returns to IDLE.
- Reset mid-WAIT: assert rst_n=0 → all outputs 0 and rd_vld=0 immediately; after release, the first pass completes normally.
